// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants and hazard FSM encoding shared by the pipeline control blocks.
package riscv_pkg;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_SB   = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one source register against every writer stage, reporting the nearest hit.
module hazard_match #(
   parameter int REG_W = 5,
   parameter int N_WB  = 2,
   parameter int FW    = $clog2(N_WB + 1)
) (
   input  logic [REG_W-1:0]      rs,
   input  logic                  used,
   input  logic [N_WB*REG_W-1:0] wb_rd,
   input  logic [N_WB-1:0]       wb_we,
   output logic                  hit,
   output logic [FW-1:0]         sel
);
   // Scan far-to-near so the nearest (lowest k) stage wins.
   always_comb begin
      sel = '0;
      for (int k = N_WB - 1; k >= 0; k--)
         if (used && wb_we[k] && wb_rd[k*REG_W +: REG_W] != '0 && wb_rd[k*REG_W +: REG_W] == rs)
            sel = FW'(k + 1);
   end
   assign hit = sel != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage RAW hazard detection, stall/flush sequencing, forwarding selects and event counters.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REG_W          = 5,
   parameter int N_WB           = 2,
   parameter int FORWARDING     = 0,
   parameter int BRANCH_PENALTY = 2,
   parameter int MAX_STALL      = 4,
   parameter int CNT_W          = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         id_valid,
   input  logic [6:0]                   id_opcode,
   input  logic [REG_W-1:0]             id_rs1,
   input  logic [REG_W-1:0]             id_rs2,
   input  logic [N_WB*REG_W-1:0]        wb_rd,
   input  logic [N_WB-1:0]              wb_we,
   input  logic [N_WB-1:0]              wb_load,
   input  logic                         br_taken,
   output logic                         pc_load,
   output logic                         if_id_load,
   output logic                         if_id_flush,
   output logic                         id_ex_bubble,
   output logic [$clog2(N_WB+1)-1:0]    fwd_a,
   output logic [$clog2(N_WB+1)-1:0]    fwd_b,
   output logic [CNT_W-1:0]             stall_cnt,
   output logic [CNT_W-1:0]             flush_cnt,
   output logic                         stall_err
);
   localparam int FW = $clog2(N_WB + 1);
   localparam int RW = BRANCH_PENALTY > 2 ? $clog2(BRANCH_PENALTY - 1) : 1;
   localparam int SW = $clog2(MAX_STALL + 1);
   // The br_taken cycle is the first bubble, so FLUSH covers the remaining BRANCH_PENALTY-1.
   localparam logic [RW-1:0] REM_INIT = RW'(BRANCH_PENALTY > 1 ? BRANCH_PENALTY - 2 : 0);
   state_t state, state_nx;
   logic [RW-1:0] rem, rem_nx;
   logic [SW-1:0] run;
   logic use1, use2, hit1, hit2, haz, haz_win;
   logic [FW-1:0] sel1, sel2;
   assign use1 = id_valid && (id_opcode inside {OP_R, OP_I, OP_LOAD, OP_S, OP_SB, OP_JALR});
   assign use2 = id_valid && (id_opcode inside {OP_R, OP_S, OP_SB});
   hazard_match #(.REG_W(REG_W), .N_WB(N_WB)) u_rs1 (
      .rs(id_rs1), .used(use1), .wb_rd(wb_rd), .wb_we(wb_we), .hit(hit1), .sel(sel1)
   );
   hazard_match #(.REG_W(REG_W), .N_WB(N_WB)) u_rs2 (
      .rs(id_rs2), .used(use2), .wb_rd(wb_rd), .wb_we(wb_we), .hit(hit2), .sel(sel2)
   );
   assign haz = FORWARDING != 0 ? (sel1 == FW'(1) || sel2 == FW'(1)) && wb_load[0] : hit1 || hit2;
   assign haz_win = !reset && !br_taken && state != FLUSH && haz;
   assign pc_load = !reset && !haz_win;
   assign if_id_load = !reset && !haz_win;
   assign if_id_flush = reset || br_taken || state == FLUSH;
   assign id_ex_bubble = if_id_flush || haz_win;
   assign fwd_a = reset || FORWARDING == 0 ? '0 : sel1;
   assign fwd_b = reset || FORWARDING == 0 ? '0 : sel2;
   always_comb begin
      state_nx = state;
      rem_nx = rem;
      if (br_taken) begin
         state_nx = BRANCH_PENALTY > 1 ? FLUSH : RUN;
         rem_nx = REM_INIT;
      end else if (state == FLUSH) begin
         state_nx = rem == '0 ? RUN : FLUSH;
         rem_nx = rem == '0 ? '0 : rem - RW'(1);
      end else
         state_nx = haz ? STALL : RUN;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
         rem <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         run <= '0;
         stall_err <= 1'b0;
      end else begin
         state <= state_nx;
         rem <= rem_nx;
         if (haz_win && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
         run <= haz_win ? (run == SW'(MAX_STALL) ? run : run + SW'(1)) : '0;
         if (haz_win && run >= SW'(MAX_STALL - 1)) stall_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of a stall-only controller (d0) and a forwarding controller (d1).
module tb_hazard_ctrl;
   import riscv_pkg::*;
   logic clock = 1'b0, reset, id_valid, br_taken;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2;
   logic [9:0] wb_rd;
   logic [1:0] wb_we, wb_load;
   logic pc0, ifl0, fl0, bub0, err0, pc1, ifl1, fl1, bub1, err1;
   logic [1:0] fa0, fb0, fa1, fb1;
   logic [15:0] sc0, fc0;
   logic [1:0] sc1, fc1;
   int checks = 0, fails = 0;
   always #5 clock = ~clock;
   hazard_ctrl #(.FORWARDING(0), .BRANCH_PENALTY(3), .MAX_STALL(4)) d0 (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .wb_rd(wb_rd), .wb_we(wb_we), .wb_load(wb_load), .br_taken(br_taken),
      .pc_load(pc0), .if_id_load(ifl0), .if_id_flush(fl0), .id_ex_bubble(bub0), .fwd_a(fa0),
      .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0), .stall_err(err0)
   );
   hazard_ctrl #(.FORWARDING(1), .BRANCH_PENALTY(1), .CNT_W(2)) d1 (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .wb_rd(wb_rd), .wb_we(wb_we), .wb_load(wb_load), .br_taken(br_taken),
      .pc_load(pc1), .if_id_load(ifl1), .if_id_flush(fl1), .id_ex_bubble(bub1), .fwd_a(fa1),
      .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1), .stall_err(err1)
   );
   typedef struct {
      logic v; logic [6:0] op; logic [4:0] r1, r2, d0, d1; logic [1:0] we, ld;
      logic s0, s1; logic [1:0] fa, fb;
   } vec_t;
   vec_t tbl[12];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", n, a, e);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d0v, input logic [4:0] d1v, input logic [1:0] we, input logic [1:0] ld);
      id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2;
      wb_rd = {d1v, d0v}; wb_we = we; wb_load = ld;
   endtask
   task automatic chk_reset_out();
      chk("rst_pc_load", pc0, 0);
      chk("rst_if_id_load", ifl0, 0);
      chk("rst_flush", fl0, 1);
      chk("rst_bubble", bub0, 1);
      chk("rst_fwd_a", fa1, 0);
   endtask
   initial begin
      tbl[0]  = '{1, OP_R,    5, 9, 5, 0, 2'b01, 2'b00, 1, 0, 1, 0};
      tbl[1]  = '{1, OP_R,    3, 7, 0, 7, 2'b10, 2'b00, 1, 0, 0, 2};
      tbl[2]  = '{1, OP_R,    3, 7, 7, 0, 2'b01, 2'b01, 1, 1, 0, 1};
      tbl[3]  = '{1, OP_R,    0, 4, 0, 9, 2'b01, 2'b01, 0, 0, 0, 0};
      tbl[4]  = '{1, OP_I,    2, 6, 6, 0, 2'b01, 2'b01, 0, 0, 0, 0};
      tbl[5]  = '{0, OP_R,    5, 5, 5, 5, 2'b11, 2'b11, 0, 0, 0, 0};
      tbl[6]  = '{1, OP_R,    5, 9, 5, 5, 2'b11, 2'b00, 1, 0, 1, 0};
      tbl[7]  = '{1, OP_R,    5, 9, 5, 0, 2'b00, 2'b00, 0, 0, 0, 0};
      tbl[8]  = '{1, OP_S,    1, 8, 0, 8, 2'b10, 2'b10, 1, 0, 0, 2};
      tbl[9]  = '{1, OP_JALR, 4, 4, 4, 0, 2'b01, 2'b01, 1, 1, 1, 0};
      tbl[10] = '{1, OP_SB,   1, 2, 2, 1, 2'b11, 2'b00, 1, 0, 2, 1};
      tbl[11] = '{1, OP_LOAD, 3, 3, 0, 3, 2'b10, 2'b00, 1, 0, 2, 0};
      reset = 1; br_taken = 0;
      set_in(1, OP_R, 5, 9, 5, 0, 2'b01, 2'b00);
      tick();
      tick();
      chk_reset_out();
      reset = 0;
      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].v, tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].d0, tbl[i].d1, tbl[i].we, tbl[i].ld);
         #1;
         chk($sformatf("v%0d_pc_load0", i), pc0, !tbl[i].s0);
         chk($sformatf("v%0d_if_id_load0", i), ifl0, !tbl[i].s0);
         chk($sformatf("v%0d_bubble0", i), bub0, tbl[i].s0);
         chk($sformatf("v%0d_flush0", i), fl0, 0);
         chk($sformatf("v%0d_fwd0", i), {fa0, fb0}, 0);
         chk($sformatf("v%0d_pc_load1", i), pc1, !tbl[i].s1);
         chk($sformatf("v%0d_fwd_a1", i), fa1, tbl[i].fa);
         chk($sformatf("v%0d_fwd_b1", i), fb1, tbl[i].fb);
         tick();
      end
      reset = 1;
      set_in(0, OP_R, 0, 0, 0, 0, 2'b00, 2'b00);
      tick();
      reset = 0;
      set_in(1, OP_R, 5, 9, 5, 0, 2'b01, 2'b00);
      #1;
      chk("s1_stall_pc", pc0, 0);
      chk("s1_stall_ifl", ifl0, 0);
      chk("s1_stall_bub", bub0, 1);
      tick();
      wb_we = 2'b00;
      #1;
      chk("s1_release_pc", pc0, 1);
      tick();
      chk("s1_stall_cnt", sc0, 1);
      chk("s1_stall_err", err0, 0);
      wb_we = 2'b01;
      #1;
      chk("s4_stall_pc", pc0, 0);
      tick();
      br_taken = 1;
      #1;
      chk("s4_br_flush", fl0, 1);
      chk("s4_br_pc", pc0, 1);
      chk("s4_br_ifl", ifl0, 1);
      chk("s4_br_bub", bub0, 1);
      tick();
      br_taken = 0; wb_we = 2'b00;
      #1;
      chk("s4_flush1", fl0, 1);
      chk("s4_flush1_bub", bub0, 1);
      chk("s4_bp1_noflush", fl1, 0);
      tick();
      wb_we = 2'b01;
      #1;
      chk("s4_flush2", fl0, 1);
      chk("s4_flush2_pc", pc0, 1);
      tick();
      wb_we = 2'b00;
      #1;
      chk("s4_run_flush", fl0, 0);
      chk("s4_run_pc", pc0, 1);
      chk("s4_flush_cnt", fc0, 1);
      chk("s4_stall_cnt", sc0, 2);
      chk("s4_flush_cnt1", fc1, 1);
      wb_we = 2'b01;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 3) chk("s5_err_early", err0, 0);
         if (n == 4) chk("s5_err_set", err0, 1);
      end
      wb_we = 2'b00;
      tick();
      chk("s5_err_sticky", err0, 1);
      br_taken = 1;
      tick();
      tick();
      chk("sat_fc_3", fc1, 3);
      tick();
      tick();
      chk("sat_fc_hold", fc1, 3);
      br_taken = 0;
      #1;
      chk("s6_in_flush", fl0, 1);
      reset = 1;
      #1;
      chk_reset_out();
      tick();
      reset = 0;
      #1;
      chk("s6_run_flush", fl0, 0);
      chk("s6_run_pc", pc0, 1);
      chk("s6_stall_cnt", sc0, 0);
      chk("s6_flush_cnt", fc0, 0);
      chk("s6_err", err0, 0);
      chk("s6_flush_cnt1", fc1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
